// File: rtl/data_mem_responder.sv
// Memory-side responder for a single-cycle core: word-addressed data RAM,
// a free-running cycle counter, and a byte-wide transmit FIFO with sticky
// overflow / decode-error status, all behind one combinational load port.
module data_mem_responder #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // Word addresses (byte address >> 2) of the peripheral registers
    localparam logic [29:0] CYCLES_WA = 30'h2000_0000;
    localparam logic [29:0] TXDATA_WA = 30'h2000_0001;
    localparam logic [29:0] STATUS_WA = 30'h2000_0002;

    // Byte offset within a word never affects the access
    logic unused_byte_offset;
    assign unused_byte_offset = ^ALUResult[1:0];

    logic [29:0]   waddr;
    logic [AW-1:0] ram_idx;
    logic          ram_sel;
    logic          cyc_sel;
    logic          tx_sel;
    logic          stat_sel;
    logic          unmapped_sel;

    assign waddr        = ALUResult[31:2];
    assign ram_idx      = ALUResult[AW+1:2];
    assign ram_sel      = (ALUResult[31:AW+2] == '0);
    assign cyc_sel      = (waddr == CYCLES_WA);
    assign tx_sel       = (waddr == TXDATA_WA);
    assign stat_sel     = (waddr == STATUS_WA);
    assign unmapped_sel = !(ram_sel || cyc_sel || tx_sel || stat_sel);

    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   cycles;
    logic          ovf;
    logic          decerr;

    logic          empty;
    logic          full;
    logic          push_req;
    logic          pop;
    logic          push_ok;
    logic          ovf_set;
    logic          ovf_clr;
    logic          decerr_set;
    logic          decerr_clr;
    logic [31:0]   status_word;

    assign empty      = (count == '0);
    assign full       = (count == CW'(FIFO_DEPTH));
    assign push_req   = MemWrite && tx_sel;
    assign pop        = !empty && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push_ok    = push_req && (!full || pop);
    assign ovf_set    = push_req && full && !pop;
    assign ovf_clr    = MemWrite && stat_sel && WriteData[2];
    assign decerr_set = MemWrite && unmapped_sel;
    assign decerr_clr = MemWrite && stat_sel && WriteData[3];

    assign status_word = {23'b0, 5'(count), decerr, ovf, full, empty};

    assign out_valid = !empty;
    assign out_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

    // Data RAM: never reset; a store seen while reset is held is dropped
    always_ff @(posedge clk) begin
        if (reset && MemWrite && ram_sel) begin
            ram[ram_idx] <= WriteData;
        end
    end

    // FIFO storage: only the slot at the write pointer changes
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= WriteData[7:0];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Cycle counter: a store clears it and takes priority over the increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles <= '0;
        end else if (MemWrite && cyc_sel) begin
            cycles <= '0;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end

    // Sticky flags: a set event in the same cycle as a clear keeps the bit set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf    <= 1'b0;
            decerr <= 1'b0;
        end else begin
            ovf    <= ovf_set    | (ovf    & ~ovf_clr);
            decerr <= decerr_set | (decerr & ~decerr_clr);
        end
    end

    // Combinational load mux; TXDATA and unmapped addresses read as zero
    always_comb begin
        ReadData = 32'h0;
        if (ram_sel) begin
            ReadData = ram[ram_idx];
        end else if (cyc_sel) begin
            ReadData = cycles;
        end else if (stat_sel) begin
            ReadData = status_word;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table for the load/store map plus
// hand-written sequences for counter, FIFO and mid-cycle reset behaviour.
// FIFO bytes are tracked by a scoreboard queue fed from the driven stores.
`timescale 1ns/100ps
module tb_data_mem_responder;

    localparam int RAM_WORDS  = 64;
    localparam int FIFO_DEPTH = 4;

    localparam logic [31:0] A_CYC  = 32'h8000_0000;
    localparam logic [31:0] A_TX   = 32'h8000_0004;
    localparam logic [31:0] A_STAT = 32'h8000_0008;
    localparam logic [31:0] A_BAD  = 32'h4000_0000;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic        mw;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    data_mem_responder #(
        .RAM_WORDS (RAM_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemWrite (MemWrite),
        .ALUResult(ALUResult),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, settle, return
    task automatic cyc(input logic mw, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
        @(posedge clk);
        #1;
        MemWrite  = mw;
        ALUResult = a;
        WriteData = wd;
        out_ready = rdy;
        #1;
    endtask

    // Scoreboard: pops compared on handshake, pushes modelled from stores
    always @(negedge clk) begin
        logic [7:0] b;
        if (!reset) begin
            exp_q.delete();
        end else begin
            chk("sb_out_valid", {31'b0, out_valid}, {31'b0, (exp_q.size() != 0)});
            if (exp_q.size() == 0) begin
                chk("sb_out_data_empty", {24'b0, out_data}, 32'h0);
            end else if (out_ready) begin
                b = exp_q.pop_front();
                chk("sb_fifo_byte", {24'b0, out_data}, {24'b0, b});
            end
            if (MemWrite && (ALUResult[31:2] == A_TX[31:2])) begin
                if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(WriteData[7:0]);
            end
        end
    end

    initial begin
        logic [7:0] drain_exp [4];

        reset     = 1'b0;
        MemWrite  = 1'b0;
        ALUResult = A_CYC;
        WriteData = 32'h0;
        out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_cycles", ReadData, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_data", {24'b0, out_data}, 32'h0);
        ALUResult = A_STAT;
        #1;
        chk("rst_status", ReadData, 32'h0000_0001);

        // Release, count ten edges, then clear the counter
        @(posedge clk);
        #1;
        reset     = 1'b1;
        ALUResult = A_CYC;
        for (int i = 0; i < 10; i++) cyc(1'b0, A_CYC, 32'h0, 1'b0);
        chk("cycles_after_10", ReadData, 32'd10);
        cyc(1'b1, A_CYC, 32'hFFFF_FFFF, 1'b0);
        cyc(1'b0, A_CYC, 32'h0, 1'b0);
        chk("cycles_cleared", ReadData, 32'd0);
        cyc(1'b0, A_CYC, 32'h0, 1'b0);
        chk("cycles_restart", ReadData, 32'd1);

        // Load/store map vectors
        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF});
        vecs.push_back('{1'b1, 32'h0000_00FC, 32'h1234_5678, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_00FE, 32'h0,         1'b1, 32'h1234_5678});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF});
        vecs.push_back('{1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{1'b0, A_STAT,        32'h0,         1'b1, 32'h0000_0001});
        vecs.push_back('{1'b0, A_TX,          32'h0,         1'b1, 32'h0});
        vecs.push_back('{1'b1, A_BAD,         32'hAAAA_AAAA, 1'b0, 32'h0});
        vecs.push_back('{1'b0, A_BAD,         32'h0,         1'b1, 32'h0});
        vecs.push_back('{1'b0, A_STAT,        32'h0,         1'b1, 32'h0000_0009});
        vecs.push_back('{1'b1, A_STAT,        32'h0000_0004, 1'b0, 32'h0});
        vecs.push_back('{1'b0, A_STAT,        32'h0,         1'b1, 32'h0000_0009});
        vecs.push_back('{1'b1, A_STAT,        32'h0000_0008, 1'b0, 32'h0});
        vecs.push_back('{1'b0, A_STAT,        32'h0,         1'b1, 32'h0000_0001});
        vecs.push_back('{1'b1, 32'h0000_0100, 32'h2222_2222, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h1111_1111});
        vecs.push_back('{1'b0, A_STAT,        32'h0,         1'b1, 32'h0000_0009});
        vecs.push_back('{1'b1, A_STAT,        32'hFFFF_FFFF, 1'b0, 32'h0});
        vecs.push_back('{1'b0, A_STAT,        32'h0,         1'b1, 32'h0000_0001});
        foreach (vecs[i]) begin
            cyc(vecs[i].mw, vecs[i].addr, vecs[i].wd, 1'b0);
            if (vecs[i].chk) chk($sformatf("vec%0d", i), ReadData, vecs[i].exp);
        end

        // Overfill with consumer stalled, then drain in order
        for (int i = 0; i < 5; i++) cyc(1'b1, A_TX, 32'h0000_0041 + i, 1'b0);
        cyc(1'b0, A_STAT, 32'h0, 1'b0);
        chk("full_ovf_status", ReadData, 32'h0000_0046);
        chk("full_head", {24'b0, out_data}, 32'h41);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, A_STAT, 32'h0, 1'b1);
            chk($sformatf("drain_head%0d", i), {24'b0, out_data}, 32'h41 + i);
        end
        cyc(1'b0, A_STAT, 32'h0, 1'b0);
        chk("drained_status", ReadData, 32'h0000_0005);
        chk("drained_valid", {31'b0, out_valid}, 32'h0);
        cyc(1'b1, A_STAT, 32'h0000_0004, 1'b0);
        cyc(1'b0, A_STAT, 32'h0, 1'b0);
        chk("ovf_cleared", ReadData, 32'h0000_0001);

        // Push and pop together while full
        for (int i = 0; i < 4; i++) cyc(1'b1, A_TX, 32'h0000_0041 + i, 1'b0);
        cyc(1'b1, A_TX, 32'h0000_0055, 1'b1);
        cyc(1'b0, A_STAT, 32'h0, 1'b0);
        chk("full_pushpop_status", ReadData, 32'h0000_0042);
        chk("full_pushpop_head", {24'b0, out_data}, 32'h42);
        drain_exp = '{8'h42, 8'h43, 8'h44, 8'h55};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, A_STAT, 32'h0, 1'b1);
            chk($sformatf("pushpop_head%0d", i), {24'b0, out_data}, {24'b0, drain_exp[i]});
        end
        cyc(1'b0, A_STAT, 32'h0, 1'b0);
        chk("pushpop_drained", ReadData, 32'h0000_0001);

        // Mid-cycle reset with bytes queued, flags set and a store pending
        cyc(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0);
        cyc(1'b1, A_BAD, 32'h0, 1'b0);
        cyc(1'b1, A_TX, 32'h0000_0061, 1'b0);
        cyc(1'b1, A_TX, 32'h0000_0062, 1'b0);
        cyc(1'b0, A_STAT, 32'h0, 1'b0);
        chk("pre_reset_status", ReadData, 32'h0000_0028);
        chk("pre_reset_valid", {31'b0, out_valid}, 32'h1);
        reset     = 1'b0;
        ALUResult = A_CYC;
        #1;
        chk("midrst_cycles", ReadData, 32'h0);
        chk("midrst_valid", {31'b0, out_valid}, 32'h0);
        chk("midrst_data", {24'b0, out_data}, 32'h0);
        ALUResult = A_STAT;
        #1;
        chk("midrst_status", ReadData, 32'h0000_0001);
        MemWrite  = 1'b1;
        ALUResult = 32'h0000_0020;
        WriteData = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        reset    = 1'b1;
        #1;
        chk("ram_retained", ReadData, 32'hCAFE_F00D);
        cyc(1'b0, A_STAT, 32'h0, 1'b0);
        chk("post_reset_status", ReadData, 32'h0000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
